// File: rtl/reset_request_generator.sv
// Reset request generator: merges debounced button, watchdog and software
// requests into one fixed-length reset_req pulse with a holdoff window and sticky cause.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; reset_req=0, busy=0
// ST_ASSERT  | reset_req=1 for PULSE_LENGTH cycles
// ST_HOLDOFF | reset_req=0, busy=1 for HOLDOFF cycles; requests discarded
module reset_request_generator #(
    parameter int DEBOUNCE     = 15,
    parameter int WDT_TIMEOUT  = 1000,
    parameter int PULSE_LENGTH = 4,
    parameter int HOLDOFF      = 16
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       button_raw,
    input  logic       sw_reset_req,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    input  logic       cause_clear,
    output logic       reset_req,
    output logic       busy,
    output logic [2:0] cause
);

    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int WDT_W   = $clog2(WDT_TIMEOUT);
    localparam int CNT_MAX = (PULSE_LENGTH > HOLDOFF) ? PULSE_LENGTH : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLDOFF
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             db_prev_q, db_prev_d;
    logic             sw_q, sw_d;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_req;
    logic [2:0]       req;
    logic [2:0]       accept;
    logic [2:0]       cause_d;
    // Power-up value only; reset_in must not wipe the record of its own cause.
    logic [2:0]       cause_q = 3'b000;

    state_t           state_q;
    logic [CNT_W-1:0] phase_cnt_q;
    logic             reset_req_q;
    logic             busy_q;

    always_comb begin
        sync1_d    = button_raw;
        sync2_d    = sync1_q;
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        db_prev_d  = db_level_q;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
            db_cnt_d   = '0;
            db_level_d = ~db_level_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        sw_d    = sw_reset_req;
        wdt_req = 1'b0;
        // A kick in the timeout cycle suppresses the request.
        if (!wdt_enable || wdt_kick) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WDT_W'(WDT_TIMEOUT - 1)) begin
            wdt_cnt_d = '0;
            wdt_req   = 1'b1;
        end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    assign req     = {sw_q, wdt_req, db_level_q & ~db_prev_q};
    assign accept  = (state_q == ST_IDLE) ? req : 3'b000;
    assign cause_d = (cause_clear ? 3'b000 : cause_q) | accept;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_cnt_q   <= '0;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            sw_q       <= 1'b0;
            wdt_cnt_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_prev_d;
            sw_q       <= sw_d;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        cause_q <= cause_d;
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            reset_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 3'b000) begin
                        state_q     <= ST_ASSERT;
                        phase_cnt_q <= CNT_W'(PULSE_LENGTH - 1);
                        reset_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (phase_cnt_q == '0) begin
                        state_q     <= ST_HOLDOFF;
                        phase_cnt_q <= CNT_W'(HOLDOFF - 1);
                        reset_req_q <= 1'b0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q - 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (phase_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    reset_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign reset_req = reset_req_q;
    assign busy      = busy_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_reset_request_generator.sv
// Bench for reset_request_generator: directed scenarios with literal checks plus
// randomized traffic, all compared every cycle against a history-based reference model.
module tb_reset_request_generator;

    localparam int D = 15;
    localparam int T = 1000;
    localparam int P = 4;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       button_raw = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       cause_clear = 1'b0;
    logic       reset_req;
    logic       busy;
    logic [2:0] cause;

    reset_request_generator #(
        .DEBOUNCE(D), .WDT_TIMEOUT(T), .PULSE_LENGTH(P), .HOLDOFF(H)
    ) dut (
        .clk(clk), .reset_in(reset_in), .button_raw(button_raw),
        .sw_reset_req(sw_reset_req), .wdt_enable(wdt_enable), .wdt_kick(wdt_kick),
        .cause_clear(cause_clear), .reset_req(reset_req), .busy(busy), .cause(cause)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: edge index e, pulse start edge, time of last watchdog
    // restart, and the recent history of the synchronized button.
    int       e       = 0;
    int       p_start = -1000000;
    int       last_wd = 0;
    bit       sw_prev = 1'b0;
    bit       s1 = 1'b1, s2 = 1'b1;
    bit       level = 1'b1;
    bit       rise_prev = 1'b0;
    bit       hist[$];
    bit [2:0] m_cause = 3'b000;

    always @(posedge clk or posedge reset_in) begin
        bit [2:0] mreq;
        bit       idle;
        bit       all_diff;
        bit       rose;
        if (reset_in) begin
            p_start   = -1000000;
            last_wd   = e;
            sw_prev   = 1'b0;
            s1        = 1'b1;
            s2        = 1'b1;
            level     = 1'b1;
            rise_prev = 1'b0;
            hist.delete();
            hist.push_back(1'b1);
        end else begin
            e++;
            mreq[2] = sw_prev;
            mreq[0] = rise_prev;
            if (!wdt_enable || wdt_kick) begin
                mreq[1] = 1'b0;
                last_wd = e;
            end else if (e - last_wd == T) begin
                mreq[1] = 1'b1;
                last_wd = e;
            end else begin
                mreq[1] = 1'b0;
            end
            idle = !((e - 1 >= p_start) && (e - 1 < p_start + P + H));
            if (idle && mreq != 3'b000) p_start = e;
            m_cause = (cause_clear ? 3'b000 : m_cause) | (idle ? mreq : 3'b000);

            all_diff = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == level) all_diff = 1'b0;
            rose = 1'b0;
            if (all_diff) begin
                level = ~level;
                rose  = level;
            end
            rise_prev = rose;

            s2 = s1;
            s1 = button_raw;
            hist.push_back(s2);
            if (hist.size() > D) void'(hist.pop_front());
            sw_prev = sw_reset_req;
        end
    end

    always @(negedge clk) begin
        chk("model_reset_req", {31'd0, reset_req}, {31'd0, (e >= p_start) && (e < p_start + P)});
        chk("model_busy", {31'd0, busy}, {31'd0, (e >= p_start) && (e < p_start + P + H)});
        chk("model_cause", {29'd0, cause}, {29'd0, m_cause});
    end

    int r_rises, r_lat, r_rr_hi, r_busy_hi;
    bit prev_rr = 1'b0;

    // Advance n cycles; strobes set before the call last exactly one edge.
    task automatic run(input int n);
        r_rises = 0; r_lat = -1; r_rr_hi = 0; r_busy_hi = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            sw_reset_req = 1'b0;
            wdt_kick     = 1'b0;
            cause_clear  = 1'b0;
            if (reset_req) begin
                r_rr_hi++;
                if (!prev_rr) begin
                    r_rises++;
                    if (r_lat < 0) r_lat = i - 1;
                end
            end
            if (busy) r_busy_hi++;
            prev_rr = reset_req;
        end
    endtask

    int acc;
    int hold;

    initial begin
        #1;
        chk("por_reset_req", {31'd0, reset_req}, 32'd0);
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_cause", {29'd0, cause}, 32'd0);
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        run(40);
        chk("idle_no_pulse", r_rises, 0);

        sw_reset_req = 1'b1;
        run(40);
        chk("sw_rises", r_rises, 1);
        chk("sw_latency", r_lat, 1);
        chk("sw_pulse_len", r_rr_hi, P);
        chk("sw_busy_len", r_busy_hi, P + H);
        chk("sw_cause", {29'd0, cause}, 32'h4);
        chk("sw_model_cause", {29'd0, m_cause}, 32'h4);

        cause_clear = 1'b1;
        run(1);
        chk("clear_cause", {29'd0, cause}, 32'h0);

        sw_reset_req = 1'b1;
        run(8);
        cause_clear = 1'b1;
        run(1);
        sw_reset_req = 1'b1;
        run(30);
        chk("holdoff_ignored", r_rises, 0);
        chk("holdoff_cause", {29'd0, cause}, 32'h0);

        sw_reset_req = 1'b1;
        run(1);
        cause_clear = 1'b1;
        run(1);
        chk("set_beats_clear", {29'd0, cause}, 32'h4);
        run(25);

        cause_clear = 1'b1;
        run(1);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            button_raw = 1'b1; run(10); acc += r_rises;
            button_raw = 1'b0; run(10); acc += r_rises;
        end
        chk("bounce_rejected", acc, 0);
        button_raw = 1'b1;
        run(30);
        chk("button_rises", r_rises, 1);
        chk("button_latency", r_lat, D + 2);
        chk("button_cause", {29'd0, cause}, 32'h1);
        button_raw = 1'b0;
        run(40);
        chk("button_release_no_pulse", r_rises, 0);

        cause_clear = 1'b1;
        wdt_enable  = 1'b1;
        run(1);
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            wdt_kick = 1'b1; run(900); acc += r_rises;
        end
        chk("wdt_kicked_no_pulse", acc, 0);
        wdt_kick = 1'b1;
        run(1100);
        chk("wdt_rises", r_rises, 1);
        chk("wdt_latency", r_lat, T);
        chk("wdt_cause", {29'd0, cause}, 32'h2);

        wdt_kick = 1'b1; run(1); acc = r_rises;
        run(T - 1); acc += r_rises;
        wdt_kick = 1'b1; run(50); acc += r_rises;
        chk("kick_at_timeout", acc, 0);

        cause_clear = 1'b1; wdt_kick = 1'b1;
        run(1);
        run(T - 2);
        acc = r_rises;
        sw_reset_req = 1'b1;
        run(30);
        chk("simul_rises", acc + r_rises, 1);
        chk("simul_pulse_len", r_rr_hi, P);
        chk("simul_cause", {29'd0, cause}, 32'h6);
        wdt_enable = 1'b0;
        run(30);

        button_raw = 1'b1;
        run(60);
        cause_clear = 1'b1;
        run(1);
        sw_reset_req = 1'b1;
        run(3);
        #2 reset_in = 1'b1;
        #1;
        chk("rst_reset_req", {31'd0, reset_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cause_kept", {29'd0, cause}, 32'h4);
        run(2);
        reset_in = 1'b0;
        run(100);
        chk("held_button_no_pulse", r_rises, 0);
        button_raw = 1'b0;
        run(40);
        button_raw = 1'b1;
        run(40);
        chk("repress_rises", r_rises, 1);
        chk("repress_cause", {29'd0, cause}, 32'h5);

        hold = 0;
        wdt_enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                button_raw = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            sw_reset_req = ($urandom_range(0, 49) == 0);
            wdt_kick     = ($urandom_range(0, 1199) == 0);
            cause_clear  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 499) == 0) wdt_enable = ~wdt_enable;
            if ($urandom_range(0, 1499) == 0) begin
                #1 reset_in = 1'b1;
                #2 reset_in = 1'b0;
            end
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_request_generator.md
# reset_request_generator

Collects reset requests from a debounced push-button, a watchdog timer and a software strobe, and emits a fixed-length, clock-synchronous reset request pulse. A holdoff window follows each pulse. `reset_req` is the upstream end of the reset path and feeds a reset synchronizer/stretcher. A sticky cause register survives the resulting system reset so firmware can read why it happened.

## Interface
- `DEBOUNCE`, 15: consecutive stable synchronized cycles before the button level is accepted (≥1)
- `WDT_TIMEOUT`, 1000: enabled cycles without a kick before a watchdog request (≥2)
- `PULSE_LENGTH`, 4: cycles `reset_req` stays high per accepted request (≥1)
- `HOLDOFF`, 16: cycles after the pulse during which new requests are discarded (≥1)
- `clk` in 1: single clock, all state on rising edge
- `reset_in` in 1: asynchronous, active-high reset
- `button_raw` in 1: asynchronous, bouncing, active-high button
- `sw_reset_req` in 1: synchronous single-cycle software request
- `wdt_enable` in 1: watchdog runs while high
- `wdt_kick` in 1: synchronous watchdog restart strobe
- `cause_clear` in 1: synchronous strobe, clears `cause`
- `reset_req` out 1: registered reset request pulse
- `busy` out 1: high in ASSERT or HOLDOFF
- `cause` out 3: sticky sources; [0] button, [1] watchdog, [2] software

## Operation
- Button path: 2-FF synchronizer → debounce counter (width `$clog2(DEBOUNCE+1)`).
  - Counter clears whenever the sync output equals the debounced level.
  - Otherwise it increments. On reaching `DEBOUNCE` the debounced level toggles and the counter clears.
  - A button request is a 0→1 transition of the debounced level.
- Watchdog: counter width `$clog2(WDT_TIMEOUT)`.
  - Held at 0 while `wdt_enable`=0.
  - `wdt_kick`=1 loads 0. Kick wins over timeout in the same cycle.
  - Otherwise it increments. At value `WDT_TIMEOUT-1` it raises a watchdog request and loads 0.
- FSM states:
  - IDLE: any request → ASSERT, pulse counter loaded.
  - ASSERT: `reset_req`=1 for `PULSE_LENGTH` cycles → HOLDOFF.
  - HOLDOFF: `HOLDOFF` cycles → IDLE.
- Requests from any source while in ASSERT/HOLDOFF are discarded and not recorded. The watchdog counter still runs and wraps normally.
- Simultaneous requests in IDLE: one pulse; all firing sources are ORed into `cause`.
- `cause`: set bits accumulate on each accepted request. `cause_clear` zeroes it. Set wins over clear in the same cycle.
- Reset (`reset_in`=1), immediately and asynchronously:
  - State goes to IDLE; `reset_req`=0, `busy`=0.
  - Watchdog and debounce counters clear; synchronizer flops are set to 1.
  - Debounced level is set to 1, so a button held across reset cannot re-trigger; it must first be released.
- `cause` is NOT affected by `reset_in`. Its power-up value is 0 via register initializer. This lets the cause survive the reset the block itself provoked.

## Timing
- `sw_reset_req` sampled high at edge N in IDLE:
  - `reset_req`, `busy` and `cause` update after edge N+1.
  - `reset_req` falls after edge N+1+`PULSE_LENGTH`.
  - `busy` falls after edge N+1+`PULSE_LENGTH`+`HOLDOFF`.
- Button: `button_raw` high and stable from before edge k, debounced level previously 0:
  - Sync output high after edge k+1.
  - Debounced level high after edge k+1+`DEBOUNCE`.
  - `reset_req` high after edge k+2+`DEBOUNCE`.
- Watchdog: enable high, last kick at edge M → request at edge M+`WDT_TIMEOUT`-1 → `reset_req` high after edge M+`WDT_TIMEOUT`.
- Gap between consecutive pulses is at least `HOLDOFF` cycles.
- `reset_in` mid-ASSERT: `reset_req` drops to 0 asynchronously. After release the block is in IDLE, with no residual pulse.

## Test plan
- SW request, defaults: `sw_reset_req` pulse at edge 10 → `reset_req` high edges 11–14 (4 cycles), `busy` high through edge 30, `cause`=3'b100.
- Bounce rejection: `button_raw` toggles with high phases of 10 cycles < `DEBOUNCE`=15 → no pulse. Then hold high 20 cycles → exactly one pulse, `cause`[0]=1, latency `DEBOUNCE`+2 from the last rising edge.
- Watchdog: enable, kick every 900 cycles for 5000 cycles → no pulse. Stop kicking → pulse 1000 cycles after the last kick, `cause`=3'b010. Kick coinciding with timeout → no pulse.
- Simultaneous: SW strobe and watchdog timeout at the same edge → single 4-cycle pulse, `cause`=3'b110.
- Holdoff and cause handling:
  - SW request during HOLDOFF → ignored, `cause` unchanged.
  - `cause_clear` → `cause`=0.
  - `cause_clear` on the same edge as an accepted request → that source's bit remains set.
- Reset: assert `reset_in` during ASSERT with `cause`=3'b100 → `reset_req`=0 immediately, `cause` stays 3'b100. Button held high across reset → no new pulse until release plus a new press.
